fetch_unit: RTL

Instruction-fetch initiator that drives the request/response channels of the instruction-memory responder and delivers one 32-bit instruction per cycle to decode. It keeps a sequential fetch PC, requests 128-bit lines (four words starting at the requested PC), buffers the returned line, and emits its words with their PCs over a valid/ready handshake. A redirect from the back end flushes buffered words, discards an in-flight response, and restarts fetch at the new PC.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_line_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option FETCH_PREFETCH_EN: two-line queue so the next line is fetched while the head drains.
package fetch_unit_pkg;

   typedef logic [31:0] bus32_t;

   localparam bus32_t      RESET_PC         = 32'h0000_0000;
   localparam int unsigned FETCH_LINE_WORDS = 4;
   localparam int unsigned FETCH_IDX_W      = $clog2(FETCH_LINE_WORDS);

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned FETCH_QUEUE_DEPTH = 2;
`else
   localparam int unsigned FETCH_QUEUE_DEPTH = 1;
`endif

   typedef logic [127:0]            fetch_line_t;
   typedef logic [FETCH_IDX_W-1:0]  fetch_idx_t;

   typedef struct packed {
      bus32_t      base;
      fetch_line_t data;
   } fetch_entry_t;

   typedef enum logic [1:0] {ISSUE, WAIT, DROP} fetch_state_e;

   function automatic bus32_t word_pc(bus32_t base, fetch_idx_t idx);
      return base + (bus32_t'(idx) << 2);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit channels: line request/response to instruction memory, redirect in, decode out.
// The master modport is the fetch unit side.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic        req_valid_o;
   logic        req_ready_i;
   bus32_t      pc_o;
   logic        rsp_valid_i;
   logic        rsp_ready_o;
   bus32_t      rsp_mem_addr_i;
   fetch_line_t instr_line_i;
   logic        redirect_valid_i;
   bus32_t      redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   bus32_t      instr_o;
   bus32_t      instr_pc_o;

   modport master (
      output req_valid_o, pc_o, rsp_ready_o, instr_valid_o, instr_o, instr_pc_o,
      input  req_ready_i, rsp_valid_i, rsp_mem_addr_i, instr_line_i,
      input  redirect_valid_i, redirect_pc_i, instr_ready_i
   );

   modport slave (
      input  req_valid_o, pc_o, rsp_ready_o, instr_valid_o, instr_o, instr_pc_o,
      output req_ready_i, rsp_valid_i, rsp_mem_addr_i, instr_line_i,
      output redirect_valid_i, redirect_pc_i, instr_ready_i
   );

endinterface

// File: rtl/fetch_line_queue.sv
// Small FIFO of fetched lines with synchronous flush; head_o is the oldest entry.
// Simultaneous push and pop is allowed even when full.
module fetch_line_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         push_i,
   input  fetch_entry_t entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   fetch_entry_t mem_q [Depth];
   fetch_entry_t mem_d [Depth];
   ptr_t         rd_q, rd_d, wr_q, wr_d;
   cnt_t         cnt_q, cnt_d;
   logic         push_ok, pop_ok;

   function automatic ptr_t incr(ptr_t p);
      return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == cnt_t'(Depth));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      pop_ok  = pop_i && !empty_o;
      push_ok = push_i && (!full_o || pop_ok);
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_q] = entry_i;
            wr_d        = incr(wr_q);
         end
         if (pop_ok) begin
            rd_d = incr(rd_q);
         end
         cnt_d = cnt_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: nothing is read while the queue is empty.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests 4-word lines, buffers them and hands out one word per cycle.
// FETCH_PREFETCH_EN (in fetch_unit_pkg) deepens the line queue to overlap fetch with drain.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input logic          clk_i,
   input logic          rstn_i,
   fetch_unit_if.master bus_io
);

   localparam fetch_idx_t LastIdx = fetch_idx_t'(FETCH_LINE_WORDS - 1);

   fetch_state_e state_q, state_d;
   bus32_t       fetch_pc_q, fetch_pc_d;
   fetch_idx_t   idx_q, idx_d;
   logic         started_q;

   logic         q_push, q_pop, q_flush, q_full, q_empty;
   fetch_entry_t q_head, q_entry;
   logic         req_valid, rsp_ready, instr_valid;
   logic         req_hs, rsp_hs, instr_hs;

   fetch_line_queue #(
      .Depth (FETCH_QUEUE_DEPTH)
   ) u_line_queue (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (q_push),
      .entry_i (q_entry),
      .pop_i   (q_pop),
      .flush_i (q_flush),
      .full_o  (q_full),
      .empty_o (q_empty),
      .head_o  (q_head)
   );

   always_comb begin
      instr_valid = !q_empty;
      instr_hs    = instr_valid && bus_io.instr_ready_i;
      q_pop       = instr_hs && (idx_q == LastIdx);
      // A line leaving the queue this cycle frees its slot for the next request.
      req_valid   = started_q && (state_q == ISSUE) && (!q_full || q_pop);
      rsp_ready   = (state_q == DROP) || ((state_q == WAIT) && !q_full);
      req_hs      = req_valid && bus_io.req_ready_i;
      rsp_hs      = rsp_ready && bus_io.rsp_valid_i;
      q_entry     = '{base: bus_io.rsp_mem_addr_i, data: bus_io.instr_line_i};
   end

   assign bus_io.req_valid_o   = req_valid;
   assign bus_io.pc_o          = fetch_pc_q;
   assign bus_io.rsp_ready_o   = rsp_ready;
   assign bus_io.instr_valid_o = instr_valid;
   assign bus_io.instr_o       = q_empty ? '0 : q_head.data[{idx_q, 5'b00000} +: 32];
   assign bus_io.instr_pc_o    = q_empty ? '0 : word_pc(q_head.base, idx_q);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      idx_d      = idx_q;
      q_push     = 1'b0;
      q_flush    = bus_io.redirect_valid_i;

      if (instr_hs) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end

      case (state_q)
         ISSUE: begin
            if (req_hs) begin
               fetch_pc_d = fetch_pc_q + 32'd16;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (rsp_hs) begin
               q_push  = !bus_io.redirect_valid_i;
               state_d = ISSUE;
            end
         end
         DROP: begin
            if (rsp_hs) begin
               state_d = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase

      if (bus_io.redirect_valid_i) begin
         fetch_pc_d = bus_io.redirect_pc_i & ~32'h3;
         idx_d      = '0;
         // Only a response still owed after this cycle has to be dropped.
         state_d    = (((state_q != ISSUE) && !rsp_hs) || req_hs) ? DROP : ISSUE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= ISSUE;
         fetch_pc_q <= RESET_PC;
         idx_q      <= '0;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         idx_q      <= idx_d;
         started_q  <= 1'b1;
      end
   end

endmodule
